// File: rtl/uart_rx_sequencer.sv
// UART receive frame sequencer driven by a 16x oversampling tick; one FSM owns tick/bit counters and the shift register.
// Optional parity stage is built when UART_RX_PARITY_EN is defined (adds PARITY_ODD and parity_error).
module uart_rx_sequencer #(
    parameter int DATA_BITS  = 8,
    parameter int SB_TICKS   = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic                 s_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 rx_done,
    output logic                 frame_error,
    output logic                 busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_error
`endif
);

    // rx_done is a one-cycle valid with no ready: the consumer must take data/frame_error
    // in that cycle or later; they stay stable until the next rx_done.
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [4:0] STOP_LAST = 5'(SB_TICKS - 1);

    state_t               state_q, state_d;
    logic [4:0]           tick_q, tick_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic                 fe_q, fe_d;
`ifdef UART_RX_PARITY_EN
    logic                 pe_q, pe_d;
    logic                 pend_q, pend_d;
`endif

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        done_d  = 1'b0;
        fe_d    = fe_q;
`ifdef UART_RX_PARITY_EN
        pe_d    = pe_q;
        pend_d  = pend_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (en && !rx) begin
                    state_d = S_START;
                    tick_d  = '0;
                end
            end
            S_START: begin
                if (s_tick) begin
                    if (tick_q == 5'd7) begin
                        tick_d  = '0;
                        state_d = rx ? S_IDLE : S_DATA;
                        bit_d   = '0;
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end
            S_DATA: begin
                if (s_tick) begin
                    if (tick_q == 5'd15) begin
                        tick_d  = '0;
                        // LSB-first line: shifting right leaves the first bit in bit 0
                        shift_d = {rx, shift_q[DATA_BITS-1:1]};
                        if (bit_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (s_tick) begin
                    if (tick_q == 5'd15) begin
                        tick_d  = '0;
                        pend_d  = ^shift_q ^ rx ^ PARITY_ODD;
                        state_d = S_STOP;
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end
`endif
            S_STOP: begin
                if (s_tick) begin
                    if (tick_q == STOP_LAST) begin
                        tick_d  = '0;
                        data_d  = shift_q;
                        fe_d    = ~rx;
                        done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
                        pe_d    = pend_q;
`endif
                        state_d = S_IDLE;
                    end else begin
                        tick_d = tick_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tick_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            fe_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_q    <= 1'b0;
            pend_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            done_q  <= done_d;
            fe_q    <= fe_d;
`ifdef UART_RX_PARITY_EN
            pe_q    <= pe_d;
            pend_q  <= pend_d;
`endif
        end
    end

    assign data        = data_q;
    assign rx_done     = done_q;
    assign frame_error = fe_q;
    assign busy        = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_error = pe_q;
`endif

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Bench for uart_rx_sequencer: directed scenarios plus randomized frames against a frame-level expected queue.
// Builds with or without UART_RX_PARITY_EN.
module tb_uart_rx_sequencer;
    localparam int DATA_BITS = 8;
    localparam int SB_TICKS  = 16;
    localparam int W         = 12; // {busy before, busy at done, parity_error, frame_error, data}
`ifdef UART_RX_PARITY_EN
    localparam bit PARITY_ODD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic en = 1'b0;
    logic s_tick = 1'b0;
    logic rx = 1'b1;
    logic [DATA_BITS-1:0] data;
    logic rx_done, frame_error, busy;
    logic pe_obs;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int tick_gap = 3;
    logic prev_busy = 1'b0;
    logic prev_done = 1'b0;
    logic busy_seen = 1'b0;
    int long_pulses = 0;
    logic [DATA_BITS-1:0] last_data = '0;

`ifdef UART_RX_PARITY_EN
    logic parity_error;
    assign pe_obs = parity_error;
    uart_rx_sequencer #(.DATA_BITS(DATA_BITS), .SB_TICKS(SB_TICKS), .PARITY_ODD(PARITY_ODD)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .s_tick(s_tick), .rx(rx),
        .data(data), .rx_done(rx_done), .frame_error(frame_error), .busy(busy),
        .parity_error(parity_error)
    );
`else
    assign pe_obs = 1'b0;
    uart_rx_sequencer #(.DATA_BITS(DATA_BITS), .SB_TICKS(SB_TICKS)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .s_tick(s_tick), .rx(rx),
        .data(data), .rx_done(rx_done), .frame_error(frame_error), .busy(busy)
    );
`endif

    // clock / reset block
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Observe outputs just after each active edge and log every rx_done.
    always @(posedge clk) begin
        #1;
        if (busy) busy_seen = 1'b1;
        if (rx_done) begin
            got_q.push_back({prev_busy, busy, pe_obs, frame_error, data});
            if (prev_done) long_pulses++;
        end
        prev_done = rx_done;
        prev_busy = busy;
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_results(input string tag);
        check({tag, "_count"}, W'(got_q.size()), W'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            check(tag, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    // driver tasks
    task automatic tick();
        repeat (tick_gap - 1) @(negedge clk);
        s_tick = 1'b1;
        @(negedge clk);
        s_tick = 1'b0;
    endtask

    task automatic hold_bit(input logic b, input int n);
        rx = b;
        repeat (n) tick();
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) tick();
    endtask

    // Drives one frame at 16 ticks/bit; the stop bit is held only until rx_done (bounded),
    // so the next call can start its start bit on the very next clock.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic pbit,
                              input logic drop_en, input logic expect_done);
        logic pe_exp;
        hold_bit(1'b0, 16);
        if (drop_en) en = 1'b0;
        for (int i = 0; i < DATA_BITS; i++) hold_bit(b[i], 16);
`ifdef UART_RX_PARITY_EN
        hold_bit(pbit, 16);
        pe_exp = ^b ^ pbit ^ PARITY_ODD;
`else
        pe_exp = 1'b0;
`endif
        rx = stop_bit;
        for (int i = 0; i < SB_TICKS + 24; i++) begin
            tick();
            if (rx_done) break;
        end
        rx = 1'b1;
        if (drop_en) en = 1'b1;
        if (expect_done) begin
            exp_q.push_back({1'b1, 1'b0, pe_exp, ~stop_bit, b});
            last_data = b;
        end
    endtask

    initial begin
        logic [7:0] rb;
        logic rs, rp, rd, rbb;

        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", W'({rx_done, frame_error, busy, pe_obs, data}), W'(0));
        reset_n = 1'b1;
        en = 1'b1;
        repeat (2) @(negedge clk);

        // basic frame
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(5);
        check_results("t1_a5");
        check("t1_data_hold", W'(data), W'(8'hA5));

        // false start: low for 4 ticks only
        busy_seen = 1'b0;
        rx = 1'b0;
        repeat (4) tick();
        rx = 1'b1;
        repeat (10) tick();
        check("t2_started", W'(busy_seen), W'(1));
        check("t2_busy", W'(busy), W'(0));
        check_results("t2_glitch");
        check("t2_data_kept", W'(data), W'(last_data));

        // bad stop bit, then a good frame clears the flag
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(6);
        check("t3_fe_hold", W'(frame_error), W'(1));
        check_results("t3_3c");
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(3);
        check_results("t3_01");
        check("t3_fe_clear", W'(frame_error), W'(0));

        // back-to-back frames with no idle gap
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        send_frame(8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(4);
        check_results("t4_b2b");

        // reset during data bit 4
        hold_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) hold_bit(((8'h5A >> i) & 8'h01) != 0, 16);
        hold_bit(1'b1, 8);
        @(negedge clk);
        reset_n = 1'b0;
        rx = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        check("t5_reset_outputs", W'({rx_done, frame_error, busy, pe_obs, data}), W'(0));
        last_data = '0;
        idle(20);
        check_results("t5_dropped");
        send_frame(8'h81, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(4);
        check_results("t5_81");

        // receiver disabled: whole frame ignored
        en = 1'b0;
        busy_seen = 1'b0;
        send_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(4);
        check("t5_en0_busy", W'(busy_seen), W'(0));
        check_results("t5_en0");
        check("t5_en0_data", W'(data), W'(8'h81));
        en = 1'b1;

        // parity cases (parity bit ignored on the line when the stage is absent)
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(3);
        check_results("t6_par_good");
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(3);
        check_results("t6_par_bad");

        // enable dropped mid-frame still completes
        send_frame(8'hC3, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(3);
        check_results("t7_en_drop");

        // randomized frames
        for (int n = 0; n < 10; n++) begin
            rb  = 8'($urandom_range(0, 255));
            rs  = ($urandom_range(0, 3) != 0);
            rp  = 1'($urandom_range(0, 1));
            rd  = ($urandom_range(0, 4) == 0);
            rbb = 1'($urandom_range(0, 1));
            tick_gap = $urandom_range(2, 5);
            send_frame(rb, rs, rp, rd, 1'b1);
            if (!rbb) idle($urandom_range(1, 12));
        end
        idle(3);
        check_results("rand");

        check("done_pulse_width", W'(long_pulses), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
